score_bcd_display: RTL and testbench



---
 rtl/score_disp_pkg.sv | 32 +++
 rtl/seg_digit_decoder.sv | 21 ++
 rtl/score_bcd_display.sv | 136 +++++++++++++
 tb/tb_score_bcd_display.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// Shared definitions for the score display driver: FSM states, active-low
// seven-segment patterns (bit order g..a) and the conversion digit count helper.
package score_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0011000   // 9
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Decimal digits needed to hold 2^width-1 (log10(2) ~= 0.301).
  function automatic int conv_digits(input int width);
    return width * 301 / 1000 + 1;
  endfunction

endpackage

// File: rtl/seg_digit_decoder.sv
// One BCD digit to an active-low seven-segment pattern (g..a).
// Dash takes priority over blank; codes above 9 render blank.
module seg_digit_decoder
  import score_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank && (digit <= 4'd9)) begin
      seg = SEG_DIGIT[digit];
    end
  end

endmodule

// File: rtl/score_bcd_display.sv
// Score to decimal seven-segment driver using a serial double-dabble engine.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the leading nonzero one.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for load; display holds the last committed value
// ST_SHIFT  | one add-3 / shift step per cycle, WIDTH steps in total
// ST_COMMIT | copy accumulator to bcd, evaluate ovf, pulse done
module score_bcd_display
  import score_disp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [WIDTH-1:0]      score,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int CONV_DIGITS = conv_digits(WIDTH);
  // The accumulator also spans the displayed digits so bcd is always a plain slice.
  localparam int ACC_DIGITS  = (CONV_DIGITS > DIGITS) ? CONV_DIGITS : DIGITS;
  localparam int ACC_W       = 4 * ACC_DIGITS;
  localparam int CNT_W       = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   sr;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_shift;
  logic [CNT_W-1:0]   count;
  logic               ovf_now;
  logic [DIGITS-1:0]  blank;

  // Add-3 correction on every digit, then shift left pulling in the score MSB.
  always_comb begin
    logic [3:0] d;
    logic       carry;
    acc_shift = '0;
    d         = '0;
    carry     = sr[WIDTH-1];
    for (int i = 0; i < ACC_DIGITS; i++) begin
      d = acc[4*i +: 4];
      if (d >= 4'd5) begin
        d = d + 4'd3;
      end
      acc_shift[4*i +: 4] = {d[2:0], carry};
      carry = d[3];
    end
  end

  generate
    if (ACC_DIGITS > DIGITS) begin : g_ovf
      assign ovf_now = |acc[ACC_W-1:4*DIGITS];
    end else begin : g_no_ovf
      assign ovf_now = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      sr    <= '0;
      acc   <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            sr    <= score;
            acc   <= '0;
            count <= CNT_W'(WIDTH);
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc   <= acc_shift;
          sr    <= {sr[WIDTH-2:0], 1'b0};
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          bcd   <= acc[4*DIGITS-1:0];
          ovf   <= ovf_now;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; blank while everything above is still zero.
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (bcd[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      seg_digit_decoder u_dec (
        .digit (bcd[4*i +: 4]),
        .blank (blank[i]),
        .dash  (ovf),
        .seg   (hex[7*i +: 7])
      );
    end
  endgenerate

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed bench for score_bcd_display: default 8-bit/3-digit instance plus a
// 10-bit/3-digit instance for the overflow cases.
module tb_score_bcd_display;

  localparam logic [6:0] H0 = 7'b1000000;
  localparam logic [6:0] H2 = 7'b0100100;
  localparam logic [6:0] H4 = 7'b0011001;
  localparam logic [6:0] H5 = 7'b0010010;
  localparam logic [6:0] H7 = 7'b1111000;
  localparam logic [6:0] H9 = 7'b0011000;
  localparam logic [6:0] HB = 7'b1111111;
  localparam logic [6:0] HD = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HZ = HB;
`else
  localparam logic [6:0] HZ = H0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        load, load10;
  logic [7:0]  score;
  logic [9:0]  score10;
  logic        busy, done, ovf;
  logic        busy10, done10, ovf10;
  logic [11:0] bcd, bcd10;
  logic [20:0] hex, hex10;

  int errors = 0;
  int checks = 0;
  int done_cnt, done_first, busy_low_first;
  int done_at [0:7];

  always #10 clk = ~clk;

  score_bcd_display #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .resetn(resetn), .score(score), .load(load),
    .busy(busy), .done(done), .ovf(ovf), .bcd(bcd), .hex(hex)
  );

  score_bcd_display #(.WIDTH(10), .DIGITS(3)) dut10 (
    .clk(clk), .resetn(resetn), .score(score10), .load(load10),
    .busy(busy10), .done(done10), .ovf(ovf10), .bcd(bcd10), .hex(hex10)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load s, watch 14 cycles after acceptance; optionally re-pulse load with s2 at cycle reload_at.
  task automatic run8(input logic [7:0] s, input int reload_at, input logic [7:0] s2);
    score = s;
    load  = 1'b1;
    tick();
    load = 1'b0;
    chk("busy_after_load", {31'd0, busy}, 32'd1);
    done_cnt       = 0;
    done_first     = -1;
    busy_low_first = -1;
    for (int c = 1; c <= 14; c++) begin
      load = (c == reload_at);
      if (c == reload_at) score = s2;
      tick();
      if (done) begin
        done_cnt++;
        if (done_first < 0) done_first = c;
      end
      if (!busy && busy_low_first < 0) busy_low_first = c;
    end
    load = 1'b0;
  endtask

  initial begin
    resetn  = 1'b0;
    load    = 1'b0;
    load10  = 1'b0;
    score   = '0;
    score10 = '0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    chk("rst_bcd",  {20'd0, bcd},  32'd0);
    chk("rst_hex",  {11'd0, hex},  {11'd0, HZ, HZ, H0});
    chk("rst_hex10", {11'd0, hex10}, {11'd0, HZ, HZ, H0});

    // score 0: latency WIDTH+1
    run8(8'd0, 0, 8'd0);
    chk("zero_latency", done_first, 9);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_bcd", {20'd0, bcd}, 32'h000);
    chk("zero_hex", {11'd0, hex}, {11'd0, HZ, HZ, H0});

    // score 255
    run8(8'd255, 0, 8'd0);
    chk("s255_bcd", {20'd0, bcd}, 32'h255);
    chk("s255_ovf", {31'd0, ovf}, 32'd0);
    chk("s255_hex", {11'd0, hex}, {11'd0, H2, H5, H5});
    chk("s255_done_cnt", done_cnt, 1);
    chk("s255_busy_fall", busy_low_first, 9);

    // load during SHIFT is ignored
    run8(8'd42, 3, 8'd7);
    chk("s42_bcd", {20'd0, bcd}, 32'h042);
    chk("s42_done_at", done_first, 9);
    chk("s42_busy_fall", busy_low_first, 9);
    chk("s42_done_cnt", done_cnt, 1);
    chk("s42_hex", {11'd0, hex}, {11'd0, HZ, H4, H2});

    // overflow on the 10-bit instance
    score10 = 10'd1000;
    load10  = 1'b1;
    tick();
    load10 = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (done10) begin
        done_cnt++;
        done_first = c;
      end
    end
    chk("w10_1000_done_at", done_first, 11);
    chk("w10_1000_ovf", {31'd0, ovf10}, 32'd1);
    chk("w10_1000_bcd", {20'd0, bcd10}, 32'h000);
    chk("w10_1000_hex", {11'd0, hex10}, {11'd0, HD, HD, HD});

    score10 = 10'd999;
    load10  = 1'b1;
    tick();
    load10 = 1'b0;
    repeat (12) tick();
    chk("w10_999_ovf", {31'd0, ovf10}, 32'd0);
    chk("w10_999_bcd", {20'd0, bcd10}, 32'h999);
    chk("w10_999_hex", {11'd0, hex10}, {11'd0, H9, H9, H9});

    // reset in the middle of a conversion
    score = 8'd200;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    resetn = 1'b0;
    #1;
    chk("midrst_bcd",  {20'd0, bcd},  32'h000);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hex",  {11'd0, hex},  {11'd0, HZ, HZ, H0});
    done_cnt = 0;
    tick();
    if (done) done_cnt++;
    tick();
    if (done) done_cnt++;
    resetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_bcd_hold", {20'd0, bcd}, 32'h000);

    run8(8'd200, 0, 8'd0);
    chk("after_rst_bcd", {20'd0, bcd}, 32'h200);
    chk("after_rst_hex", {11'd0, hex}, {11'd0, H2, H0, H0});

    // back-to-back loads: one commit every WIDTH+2 cycles
    score = 8'd77;
    load  = 1'b1;
    tick();
    done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) begin
        if (done_cnt < 8) done_at[done_cnt] = c;
        done_cnt++;
      end
    end
    load = 1'b0;
    chk("b2b_done_cnt", done_cnt, 4);
    chk("b2b_done0", done_at[0], 9);
    chk("b2b_done1", done_at[1], 19);
    chk("b2b_done2", done_at[2], 29);
    chk("b2b_done3", done_at[3], 39);
    chk("b2b_bcd", {20'd0, bcd}, 32'h077);
    chk("b2b_hex", {11'd0, hex}, {11'd0, HZ, H7, H7});
    repeat (12) tick();
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
